// File: rtl/mem_access_ctrl.sv
// Data-memory initiator for the single-cycle core: turns byte/half/word requests
// into word-aligned accesses, doing sub-word stores as read-modify-write.
module mem_access_ctrl #(
    parameter int ADDRSIZE = 32,
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDRSIZE-1:0] req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic                resp_err,
    output logic                mem_wren,
    output logic                mem_rden,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_d,
    input  logic [WORDSIZE-1:0] mem_q
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                err_q, err_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;
    logic [WORDSIZE-1:0] buf_q, buf_d;

    logic                misaligned;
    logic [3:0]          byte_en;
    logic [WORDSIZE-1:0] wdata_rep;
    logic [WORDSIZE-1:0] merged;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [WORDSIZE-1:0] ld_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        misaligned = ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_size == 2'b11);
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = misaligned;
                    if (misaligned)
                        state_d = RESP;
                    else if (req_we && (req_size == SZ_WORD))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                buf_d   = mem_q;
                state_d = we_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store merge: replicate the store data across lanes, then pick per-lane
    // between it and the read buffer using a byte-enable mask.
    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = wdata_q;
        unique case (size_q)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
        merged = buf_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i])
                merged[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    ld_byte = buf_q[7:0];
            2'd1:    ld_byte = buf_q[15:8];
            2'd2:    ld_byte = buf_q[23:16];
            default: ld_byte = buf_q[31:24];
        endcase
        ld_half = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
        unique case (size_q)
            SZ_BYTE: ld_ext = uns_q ? {{(WORDSIZE-8){1'b0}}, ld_byte}
                                    : {{(WORDSIZE-8){ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = uns_q ? {{(WORDSIZE-16){1'b0}}, ld_half}
                                    : {{(WORDSIZE-16){ld_half[15]}}, ld_half};
            default: ld_ext = buf_q;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && !rst;
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ld_ext : '0;
        mem_rden   = (state_q == RD);
        mem_wren   = (state_q == WR);
        mem_addr   = ((state_q == RD) || (state_q == WR)) ? (addr_q >> 2) : '0;
        mem_d      = (state_q == WR) ? merged : '0;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the single-cycle core's word-wide data-memory interface (wren, rden, addr, d, q).
- Accepts byte, halfword and word load/store requests from the core and converts them into word-aligned memory accesses.
- Sub-word stores are done as read-modify-write; loads are extracted and sign- or zero-extended.
- Rejects misaligned or reserved-size requests with an error response; no memory access is issued for them.

Parameters:
ADDRSIZE, 32, width of the core byte address and of the memory word-address bus
WORDSIZE, 32, data width; fixed at 32 (four byte lanes, little-endian)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  core request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  ADDRSIZE  byte address
req_wdata  input  WORDSIZE  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  WORDSIZE  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or reserved-size request, valid with resp_valid
mem_wren  output  1  memory write enable
mem_rden  output  1  memory read enable
mem_addr  output  ADDRSIZE  word address = req_addr >> 2 (zero-filled upper bits)
mem_d  output  WORDSIZE  memory write data
mem_q  input  WORDSIZE  memory read data, combinational from mem_addr

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_wren=0, mem_rden=0, mem_addr=0, mem_d=0. req_ready=0 while rst is high.
- Reset mid-operation aborts the transaction: no response is issued. A write is never issued after reset deasserts.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1; all memory outputs are 0.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with err=1.
  - Load or sub-word store -> RD.
  - Word store -> WR.
- RD:
  - mem_rden=1, mem_addr=latched word address.
  - mem_q is captured into the read buffer at the clock edge.
  - Load -> RESP; store -> WR.
- WR:
  - mem_wren=1, mem_addr=word address.
  - Word store: mem_d=wdata.
  - Byte store: mem_d=buffer with lane addr[1:0] replaced by wdata[7:0].
  - Half store: mem_d=buffer with lanes {addr[1],0} and {addr[1],1} replaced by wdata[15:0].
  - Next state is RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; all memory outputs are 0.
  - Load resp_rdata: byte = buffer[8*addr[1:0]+:8]; half = buffer[16*addr[1]+:16]; word = buffer. Extend per unsigned flag.
  - Next state is IDLE.
- Latency, counted from the accept edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2;
  - sub-word store: 3;
  - error: 1.
- Next acceptance is possible in the cycle after RESP.
- mem_rden and mem_wren are never both high. At most one write per request.
- req_ready and resp_valid are never high in the same cycle.
- Requests presented while req_ready=0 are ignored. The core holds them until accepted.

Test Plan:
- Reset asserted mid-RD of a load -> resp_valid stays 0; after release req_ready=1 and all memory outputs are 0.
- Word store addr 0x100 data 0xDEADBEEF, then word load 0x100 -> mem_wren pulse with mem_addr 0x40, mem_d 0xDEADBEEF; load resp_rdata 0xDEADBEEF, err 0, resp 2 cycles after accept.
- Byte store 0xA5 to addr 0x101 over word 0x11223344 -> RD then WR with mem_d 0x1122A544; resp 3 cycles after accept.
- Loads from word 0x8000FF80:
  - signed byte at offset 0 -> 0xFFFFFF80;
  - unsigned byte at offset 0 -> 0x00000080;
  - signed half at offset 2 -> 0xFFFF8000;
  - unsigned half at offset 2 -> 0x00008000.
- Half store at addr 0x103 and word load at 0x102 -> resp_err=1 one cycle after accept; no mem_wren/mem_rden pulse; resp_rdata 0.
- Back-to-back requests with req_valid held high -> accepts only in IDLE cycles; resp_valid and req_ready are never simultaneously high.
